// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load-use stall and branch flush.
// Define MULDIV_STALL_EN to add the multi-cycle mul/div busy stall.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       branch_taken,
  input  logic       md_start,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall,
  output logic       flush_if,
  output logic       flush_id,
  output logic       md_busy,
  output logic       md_done
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  // Index 0 = ex, 1 = mem, 2 = wb.
  slot_t      r_slot [0:2];
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic       w_md_busy;
  logic       w_flush;
  logic       w_load_use;
  logic [1:0] w_hit_rs1;
  logic [1:0] w_hit_rs2;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  function automatic logic f_match(input slot_t s, input logic [4:0] src);
    return s.valid && s.reg_write && (s.rd != 5'd0) && (s.rd == src);
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign w_hit_rs1[gi] = f_match(r_slot[gi], id_rs1);
      assign w_hit_rs2[gi] = f_match(r_slot[gi], id_rs2);
    end
  endgenerate

  // Newer producer (ex) wins over the older one (mem).
  assign w_sel_a = w_hit_rs1[0] ? 2'd1 : (w_hit_rs1[1] ? 2'd2 : 2'd0);
  assign w_sel_b = w_hit_rs2[0] ? 2'd1 : (w_hit_rs2[1] ? 2'd2 : 2'd0);

  assign w_flush    = branch_taken & ~w_md_busy;
  assign w_load_use = id_valid & r_slot[0].mem_read & ~w_flush & ~w_md_busy &
                      ((id_use_rs1 & w_hit_rs1[0]) | (id_use_rs2 & w_hit_rs2[0]));

  assign stall     = w_load_use | w_md_busy;
  assign flush_if  = w_flush;
  assign flush_id  = w_flush;
  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_slot[i] <= '0;
      end
      r_fwd_a <= 2'd0;
      r_fwd_b <= 2'd0;
    end else if (!w_md_busy) begin
      r_slot[2]           <= r_slot[1];
      r_slot[1]           <= r_slot[0];
      r_slot[0].valid     <= id_valid & ~w_flush & ~w_load_use;
      r_slot[0].rd        <= id_rd;
      r_slot[0].reg_write <= id_reg_write;
      r_slot[0].mem_read  <= id_mem_read;
      r_fwd_a             <= w_load_use ? 2'd0 : w_sel_a;
      r_fwd_b             <= w_load_use ? 2'd0 : w_sel_b;
    end
  end

`ifdef MULDIV_STALL_EN
  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  logic [CW-1:0] r_md_cnt;
  logic          r_md_busy;
  logic          r_md_done;

  // Counter runs DIV_CYCLES-1 down to 0; done is raised during the count-0 cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_md_cnt  <= '0;
      r_md_busy <= 1'b0;
      r_md_done <= 1'b0;
    end else if (r_md_busy) begin
      if (r_md_cnt == '0) begin
        r_md_busy <= 1'b0;
        r_md_done <= 1'b0;
      end else begin
        r_md_cnt  <= r_md_cnt - 1'b1;
        r_md_done <= (r_md_cnt == CW'(1));
      end
    end else if (md_start) begin
      r_md_busy <= 1'b1;
      r_md_cnt  <= CW'(DIV_CYCLES - 1);
      r_md_done <= (DIV_CYCLES == 1);
    end
  end

  assign w_md_busy = r_md_busy;
  assign md_busy   = r_md_busy;
  assign md_done   = r_md_done;
`else
  logic w_unused_md;

  assign w_unused_md = md_start | (DIV_CYCLES < 1);
  assign w_md_busy   = 1'b0;
  assign md_busy     = 1'b0;
  assign md_done     = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a slot-list / cycles-left reference model.
module tb_hazard_ctrl;
  localparam int TB_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       branch_taken, md_start;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, flush_if, flush_id, md_busy, md_done;

  always #5 clk = ~clk;

  hazard_ctrl #(.DIV_CYCLES(TB_DIV)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .branch_taken(branch_taken), .md_start(md_start),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall(stall), .flush_if(flush_if), .flush_id(flush_id),
    .md_busy(md_busy), .md_done(md_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: list of in-flight instructions (0 = ex, 1 = mem, 2 = wb)
  // and the number of busy cycles left for mul/div.
  bit         m_v [3];
  logic [4:0] m_rd [3];
  bit         m_rw [3];
  bit         m_mr [3];
  int         m_fa, m_fb;
  int         m_left;
  bit         m_known = 1'b0;

  bit s_stall, s_fi, s_fid, s_busy, s_done;

  function automatic bit produces(input int k, input logic [4:0] src);
    return m_v[k] && m_rw[k] && (m_rd[k] != 5'd0) && (m_rd[k] == src);
  endfunction

  function automatic int newest(input logic [4:0] src);
    for (int k = 0; k < 2; k++)
      if (produces(k, src)) return k + 1;
    return 0;
  endfunction

  task automatic step(input bit r, input bit v, input bit u1, input bit u2,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                      input bit rw, input bit mr, input bit br, input bit ms);
    bit busy, e_flush, e_lu;
    int na, nb;
    rst = r; id_valid = v; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rs1 = s1; id_rs2 = s2; id_rd = d; id_reg_write = rw; id_mem_read = mr;
    branch_taken = br; md_start = ms;
    #1;
    busy    = (m_left > 0);
    e_flush = br && !busy;
    e_lu    = v && !busy && !e_flush && m_v[0] && m_mr[0] &&
              ((u1 && produces(0, s1)) || (u2 && produces(0, s2)));
    s_stall = stall; s_fi = flush_if; s_fid = flush_id; s_busy = md_busy; s_done = md_done;
    if (m_known) begin
      check_eq("stall", int'(stall), int'(e_lu || busy));
      check_eq("flush_if", int'(flush_if), int'(e_flush));
      check_eq("flush_id", int'(flush_id), int'(e_flush));
      check_eq("fwd_a_sel", int'(fwd_a_sel), m_fa);
      check_eq("fwd_b_sel", int'(fwd_b_sel), m_fb);
      check_eq("md_busy", int'(md_busy), int'(busy));
      check_eq("md_done", int'(md_done), int'(m_left == 1));
    end
    na = e_lu ? 0 : newest(s1);
    nb = e_lu ? 0 : newest(s2);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        m_v[k] = 0; m_rd[k] = 0; m_rw[k] = 0; m_mr[k] = 0;
      end
      m_fa = 0; m_fb = 0; m_left = 0; m_known = 1'b1;
    end else if (busy) begin
      m_left--;
    end else begin
      for (int k = 2; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_rw[k] = m_rw[k-1]; m_mr[k] = m_mr[k-1];
      end
      m_v[0] = v && !e_flush && !e_lu; m_rd[0] = d; m_rw[0] = rw; m_mr[0] = mr;
      m_fa = na; m_fb = nb;
`ifdef MULDIV_STALL_EN
      if (ms) m_left = TB_DIV;
`endif
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    m_left = 0; m_fa = 0; m_fb = 0;
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    check_eq("rst_fwd_a", int'(fwd_a_sel), 0);
    check_eq("rst_fwd_b", int'(fwd_b_sel), 0);
    check_eq("rst_stall", int'(stall), 0);
    check_eq("rst_flush", int'(flush_if), 0);
    check_eq("rst_busy", int'(md_busy), 0);

    // Forwarding from ex, from mem, and never from x0.
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
    step(0, 1, 1, 1, 5'd5, 5'd1, 5'd6, 1, 0, 0, 0);
    check_eq("fwd_ex", int'(fwd_a_sel), 1);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0);
    step(0, 1, 1, 0, 5'd5, 5'd0, 5'd10, 1, 0, 0, 0);
    check_eq("fwd_mem", int'(fwd_a_sel), 2);
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 5'd0, 5'd0, 5'd11, 1, 0, 0, 0);
    check_eq("x0_stall", int'(s_stall), 0);
    check_eq("x0_fwd", int'(fwd_a_sel), 0);

    // Load-use: one stall cycle, then the consumer takes the mem result.
    step(0, 1, 1, 0, 5'd1, 5'd2, 5'd7, 1, 1, 0, 0);
    step(0, 1, 1, 1, 5'd3, 5'd7, 5'd8, 1, 0, 0, 0);
    check_eq("lu_stall1", int'(s_stall), 1);
    step(0, 1, 1, 1, 5'd3, 5'd7, 5'd8, 1, 0, 0, 0);
    check_eq("lu_stall2", int'(s_stall), 0);
    check_eq("lu_fwd_b", int'(fwd_b_sel), 2);

    // Branch beats load-use; ex becomes a bubble.
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd7, 1, 1, 0, 0);
    step(0, 1, 1, 0, 5'd7, 5'd0, 5'd12, 1, 0, 1, 0);
    check_eq("br_stall", int'(s_stall), 0);
    check_eq("br_flush_if", int'(s_fi), 1);
    check_eq("br_flush_id", int'(s_fid), 1);
    step(0, 1, 1, 0, 5'd7, 5'd0, 5'd13, 1, 0, 0, 0);
    check_eq("br_bubble_stall", int'(s_stall), 0);
    check_eq("br_bubble_fwd", int'(fwd_a_sel), 2);

`ifdef MULDIV_STALL_EN
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
    step(0, 1, 1, 0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 1);
    for (int i = 0; i < TB_DIV; i++) begin
      step(0, 1, 1, 1, 5'd6, 5'd6, 5'd14, 1, 0, 1, 0);
      check_eq("md_busy_on", int'(s_busy), 1);
      check_eq("md_stall", int'(s_stall), 1);
      check_eq("md_noflush", int'(s_fi), 0);
      check_eq("md_done_pulse", int'(s_done), int'(i == TB_DIV - 1));
      check_eq("md_fwd_hold", int'(fwd_a_sel), 1);
    end
    idle();
    check_eq("md_busy_off", int'(s_busy), 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
    idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    check_eq("md_rst_busy", int'(md_busy), 0);
    check_eq("md_rst_stall", int'(stall), 0);
    check_eq("md_rst_fwd_a", int'(fwd_a_sel), 0);
    check_eq("md_rst_fwd_b", int'(fwd_b_sel), 0);
`else
    step(0, 1, 0, 0, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0);
    step(0, 1, 1, 0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 1);
    check_eq("nomd_busy", int'(md_busy), 0);
    check_eq("nomd_fwd", int'(fwd_a_sel), 1);
    step(0, 1, 1, 0, 5'd5, 5'd0, 5'd8, 1, 0, 0, 1);
    check_eq("nomd_stall", int'(s_stall), 0);
    check_eq("nomd_fwd_mem", int'(fwd_a_sel), 2);
`endif
    idle();

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(63) == 0, $urandom_range(3) != 0,
           1'($urandom), 1'($urandom),
           5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
           $urandom_range(3) != 0, $urandom_range(2) == 0,
           $urandom_range(7) == 0, $urandom_range(15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The parameter DIV_CYCLES SHALL default to 32 and set the number of busy cycles of one multi-cycle mul/div operation.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on the rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-004 Ports id_valid, id_use_rs1, id_use_rs2, id_reg_write and id_mem_read SHALL be 1-bit inputs qualifying the instruction currently in ID.
REQ-005 Ports id_rs1, id_rs2 and id_rd SHALL be 5-bit inputs carrying the register indices of the ID instruction.
REQ-006 Port branch_taken SHALL be a 1-bit input indicating that the EX-stage instruction redirects the PC.
REQ-007 Port md_start SHALL be a 1-bit input indicating that the EX-stage instruction starts a mul/div operation.
REQ-008 Ports fwd_a_sel and fwd_b_sel SHALL be 2-bit outputs driving the select of the EX operand A/B 3-input mux: 0 = register file, 1 = MEM result, 2 = WB result; value 3 is never driven.
REQ-009 Ports stall, flush_if and flush_id SHALL be 1-bit outputs: stall holds PC and IF/ID; flush_if and flush_id squash IF/ID and ID/EX respectively.
REQ-010 Ports md_busy and md_done SHALL be 1-bit outputs giving mul/div status.

Function
REQ-011 The block SHALL keep three shadow slots (ex, mem, wb), each holding {valid, rd, reg_write, mem_read}.
REQ-012 When the pipeline advances, each clock edge SHALL shift wb<=mem, mem<=ex and ex<=ID info, with slot valid = id_valid && !flush && !stall.
REQ-013 A slot SHALL match a source register only when slot valid=1, reg_write=1, rd!=0 and rd equals the source.
REQ-014 fwd_a_sel SHALL be registered on the same edge that loads the ex slot: 1 if the current ex slot matches id_rs1, else 2 if the current mem slot matches it, else 0; fwd_b_sel SHALL be derived the same way from id_rs2.
REQ-015 The newer producer SHALL take priority when both slots match (sel=1).
REQ-016 Load-use stall (combinational) SHALL assert when id_valid=1 and the ex slot has mem_read=1 and matches a used source (id_use_rs1/id_use_rs2).
REQ-017 During a load-use stall the ex slot SHALL load a bubble, mem and wb SHALL still shift, fwd selects SHALL load 0, and stall SHALL last exactly 1 cycle, after which the consumer gets sel=2.
REQ-018 When branch_taken=1 and md_busy=0, flush_if and flush_id SHALL assert combinationally in that cycle, the ex slot SHALL load a bubble on the next edge, and load-use stall SHALL be suppressed (flush wins).
REQ-019 x0 SHALL never forward or stall, even when id_use_rs*=1.

Reset
REQ-020 While rst=1 on a clock edge, all slots SHALL clear to invalid and fwd_a_sel=fwd_b_sel=0.
REQ-021 Reset SHALL also clear md_busy=0, md_done=0 and the mul/div counter to 0.
REQ-022 Combinational outputs SHALL evaluate to stall=0, flush_if=0 and flush_id=0 after reset.
REQ-023 Reset asserted mid-stall or mid-mul/div SHALL abort the operation on that edge.

Configuration
REQ-024 With macro MULDIV_STALL_EN defined, md_start sampled while md_busy=0 SHALL set md_busy=1 and load the counter with DIV_CYCLES-1 on the next edge.
REQ-025 With MULDIV_STALL_EN defined, while md_busy=1 stall SHALL be 1, all slots and fwd selects SHALL freeze, flush outputs SHALL be 0, and branch_taken SHALL be ignored.
REQ-026 With MULDIV_STALL_EN defined, the counter SHALL decrement each busy cycle, and md_done SHALL pulse for 1 cycle when the counter is 0, with md_busy dropping on the following edge, giving exactly DIV_CYCLES busy cycles.
REQ-027 With MULDIV_STALL_EN defined, md_start arriving together with branch_taken SHALL be honored and the flush SHALL still occur.
REQ-028 Without MULDIV_STALL_EN, md_start SHALL be ignored, md_busy and md_done SHALL be tied to 0, and no counter SHALL exist.

Verification
REQ-029 A bench SHALL cover: add x5 (EX), then ID add uses rs1=x5 -> next cycle fwd_a_sel=1; one instruction gap -> fwd_a_sel=2; rd=x0 -> 0.
REQ-030 A bench SHALL cover: lw x7 in ex slot, ID uses rs2=x7 -> stall=1 for exactly 1 cycle, then fwd_b_sel=2, no second stall.
REQ-031 A bench SHALL cover: branch_taken=1 in the same cycle as a load-use condition -> flush_if=flush_id=1, stall=0, and the ex slot is a bubble next cycle.
REQ-032 A bench SHALL cover: with MULDIV_STALL_EN and DIV_CYCLES=4, pulse md_start -> md_busy=1 for 4 cycles, md_done pulses in the 4th busy cycle, and fwd selects hold.
REQ-033 A bench SHALL cover: rst=1 during the 2nd busy cycle -> next cycle md_busy=0, stall=0, and all selects are 0.
REQ-034 A bench SHALL cover: build without MULDIV_STALL_EN and pulse md_start -> md_busy stays 0 and the pipeline advances unchanged.
